// File: rtl/hkspi_pkg.sv
// Housekeeping SPI front end: shared command constants, FSM state type
// and command-field decode helpers.
package hkspi_pkg;

  localparam logic [1:0] CMD_NOP       = 2'b00;
  localparam logic [1:0] CMD_RD        = 2'b01;
  localparam logic [1:0] CMD_WR        = 2'b10;
  localparam logic [1:0] CMD_RW        = 2'b11;
  localparam logic [7:0] CMD_PASS_MGMT = 8'hC4;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE,
    PASS
  } hkspi_state_t;

  function automatic logic op_reads(input logic [1:0] op);
    return (op == CMD_RD) || (op == CMD_RW);
  endfunction

  function automatic logic op_writes(input logic [1:0] op);
    return (op == CMD_WR) || (op == CMD_RW);
  endfunction

endpackage

// File: rtl/hkspi_if.sv
// Housekeeping register-bank bus: address, write data, single-cycle
// write/read strobes, and read data returned by the bank.
interface hkspi_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/hkspi_sync.sv
// Multi-stage synchronizer for an asynchronous pad input, with rise and
// fall detection on the synchronized level.
module hkspi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_q_d;

  // Shift the pad value through the synchronizer and keep one delayed copy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_q_d  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_q_d  <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise =  o_q & ~r_q_d;
  assign o_fall = ~o_q &  r_q_d;

endmodule

// File: rtl/hkspi_frontend.sv
// Housekeeping SPI slave front end. Oversamples SCK/CSB/SDI in the core
// clock domain, decodes command/address/data bytes and issues one-clock
// read/write strobes to the register bank; shifts read data out on SDO.
// Optional feature macro: HKSPI_FE_PASSTHRU_EN (management-flash pass-through
// on command 0xC4; without it 0xC4 is treated as a NOP).
module hkspi_frontend
  import hkspi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic  clock,
  input  logic  resetb,
  input  logic  sck,
  input  logic  csb,
  input  logic  sdi,
  output logic  sdo,
  output logic  sdo_enb,
  output logic  pass_mgmt,
  hkspi_if.master reg_bus
);

  logic w_sck_rise, w_sck_q_unused, w_sck_fall_unused;
  logic w_csb_q, w_csb_fall, w_csb_rise_unused;

  hkspi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .i_clk(clock), .i_rst_n(resetb), .i_d(sck),
    .o_q(w_sck_q_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall_unused)
  );

  hkspi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb_sync (
    .i_clk(clock), .i_rst_n(resetb), .i_d(csb),
    .o_q(w_csb_q), .o_rise(w_csb_rise_unused), .o_fall(w_csb_fall)
  );

  logic [SYNC_STAGES-1:0] r_sdi_sync;

  // SDI data-path synchronizer, same depth as SCK so bits line up with edges
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) r_sdi_sync <= '0;
    else         r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
  end

  hkspi_state_t r_state;
  logic [2:0]   r_bitcnt, r_nbytes, r_bytecnt;
  logic [6:0]   r_shift;
  logic         r_rd, r_wr, r_adv;
  logic [7:0]   r_addr, r_wdata, r_sdo_sr;
  logic         r_we, r_re, r_re_d, r_sdo_enb;
  logic [7:0]   w_byte;
  logic         w_load, w_last;

  assign w_byte = {r_shift, r_sdi_sync[SYNC_STAGES-1]};
  assign w_last = (r_nbytes != 3'd0) && ((r_bytecnt + 3'd1) == r_nbytes);
  assign w_load = (RD_LAT == 0) ? r_re : r_re_d;

`ifdef HKSPI_FE_PASSTHRU_EN
  logic r_pass;
  assign pass_mgmt = r_pass;
`else
  assign pass_mgmt = 1'b0;
`endif

  // Byte-stream FSM with registered strobes, address and SDO shifter.
  // A completed data byte raises reg_we first; the address advance and the
  // prefetch read for the next address follow one clock later (r_adv), so a
  // read of an address always lands before any write to it.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state   <= IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_nbytes  <= '0;
      r_bytecnt <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_re_d    <= 1'b0;
      r_adv     <= 1'b0;
      r_sdo_sr  <= '0;
      r_sdo_enb <= 1'b1;
`ifdef HKSPI_FE_PASSTHRU_EN
      r_pass    <= 1'b0;
`endif
    end else begin
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_adv     <= 1'b0;
      r_re_d    <= r_re;
      r_sdo_enb <= !((r_state == DATA) && r_rd);
`ifdef HKSPI_FE_PASSTHRU_EN
      r_pass    <= (r_state == PASS) && !w_csb_q;
`endif
      if (w_load) r_sdo_sr <= reg_bus.reg_rdata;
      if (r_adv && !w_csb_q) begin
        r_addr <= r_addr + 8'd1;
        r_re   <= r_rd && (r_state == DATA);
      end

      if (w_csb_q) begin
        r_state  <= IDLE;
        r_bitcnt <= '0;
        r_shift  <= '0;
        r_rd     <= 1'b0;
        r_wr     <= 1'b0;
      end else begin
        if ((r_state == IDLE) && w_csb_fall) begin
          r_state  <= CMD;
          r_bitcnt <= '0;
        end
        if (w_sck_rise && (r_state inside {CMD, ADDR, DATA})) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          r_shift  <= w_byte[6:0];
          if (r_state == DATA) r_sdo_sr <= {r_sdo_sr[6:0], 1'b0};
          if (r_bitcnt == 3'd7) begin
            case (r_state)
              CMD: begin
                if (w_byte == CMD_PASS_MGMT) begin
                  r_rd <= 1'b0;
                  r_wr <= 1'b0;
`ifdef HKSPI_FE_PASSTHRU_EN
                  r_state <= PASS;
`else
                  r_state <= DONE;
`endif
                end else if (w_byte[7:6] == CMD_NOP) begin
                  r_rd    <= 1'b0;
                  r_wr    <= 1'b0;
                  r_state <= DONE;
                end else begin
                  r_rd     <= op_reads(w_byte[7:6]);
                  r_wr     <= op_writes(w_byte[7:6]);
                  r_nbytes <= w_byte[5:3];
                  r_state  <= ADDR;
                end
              end
              ADDR: begin
                r_addr    <= w_byte;
                r_re      <= r_rd;
                r_bytecnt <= '0;
                r_state   <= DATA;
              end
              DATA: begin
                r_bytecnt <= r_bytecnt + 3'd1;
                r_adv     <= 1'b1;
                if (r_wr) begin
                  r_wdata <= w_byte;
                  r_we    <= 1'b1;
                end
                if (w_last) r_state <= DONE;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign sdo               = r_sdo_sr[7];
  assign sdo_enb           = r_sdo_enb;
  assign reg_bus.reg_addr  = r_addr;
  assign reg_bus.reg_wdata = r_wdata;
  assign reg_bus.reg_we    = r_we;
  assign reg_bus.reg_re    = r_re;

endmodule
